// File: rtl/d_nextpc_ctrl_pkg.sv
// d_ctrl_pkg: shared decode constants for the decode-stage next-PC controller.
//   - MIPS opcode / funct encodings used by D-stage decode and hazard logic
//   - PCSrc encodings consumed by the fetch PC register
//   - Tuse constants and an operand-usage decode helper
package d_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type functs: shifts by immediate (read rt only)
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  // shifts by register
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  // mult/div family
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  // three-register ALU
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'b000,
    PCSRC_BRANCH = 3'b001,
    PCSRC_JUMP   = 3'b010,
    PCSRC_JR     = 3'b011
  } pcsrc_e;

  // Cycles from D until the operand is consumed.
  localparam logic [1:0] TUSE_D     = 2'd0;  // compared in D (branch, jr)
  localparam logic [1:0] TUSE_E     = 2'd1;  // ALU / address / mult-div input
  localparam logic [1:0] TUSE_M     = 2'd2;  // store data

  typedef struct packed {
    logic       rs_read;
    logic [1:0] rs_tuse;
    logic       rt_read;
    logic [1:0] rt_tuse;
    logic       md_op;
  } tuse_t;

  // Which operands an instruction reads, when it needs them, and whether it
  // touches the multiplier/divider (and so must wait out md_busy).
  function automatic tuse_t decode_tuse(input logic [5:0] op, input logic [5:0] funct);
    tuse_t t;
    t = '{rs_read: 1'b0, rs_tuse: TUSE_E, rt_read: 1'b0, rt_tuse: TUSE_E, md_op: 1'b0};
    case (op)
      OP_BEQ, OP_BNE: begin
        t.rs_read = 1'b1; t.rs_tuse = TUSE_D;
        t.rt_read = 1'b1; t.rt_tuse = TUSE_D;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
        t.rs_read = 1'b1; t.rs_tuse = TUSE_E;
      end
      OP_SW: begin
        t.rs_read = 1'b1; t.rs_tuse = TUSE_E;
        t.rt_read = 1'b1; t.rt_tuse = TUSE_M;
      end
      OP_RTYPE: begin
        case (funct)
          FN_JR: begin
            t.rs_read = 1'b1; t.rs_tuse = TUSE_D;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            t.rt_read = 1'b1; t.rt_tuse = TUSE_E;
          end
          FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            t.rs_read = 1'b1; t.rs_tuse = TUSE_E;
            t.rt_read = 1'b1; t.rt_tuse = TUSE_E;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            t.rs_read = 1'b1; t.rs_tuse = TUSE_E;
            t.rt_read = 1'b1; t.rt_tuse = TUSE_E;
            t.md_op   = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            t.rs_read = 1'b1; t.rs_tuse = TUSE_E;
            t.md_op   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            t.md_op   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;  // j, jal, lui and unknown opcodes read no registers
    endcase
    return t;
  endfunction

endpackage

// File: rtl/d_nextpc_ctrl_hazard_unit.sv
// d_hazard_unit: decode-stage interlock.
//   Inputs : D_op/D_funct/D_rs/D_rt  fields of the instruction in D
//            E_wa/E_tnew, M_wa/M_tnew  pending destinations and their Tnew
//            md_busy                   multiplier/divider busy or starting
//   Output : stall                     hold PC and IF/ID, bubble into E
module d_hazard_unit
  import d_ctrl_pkg::*;
#(
  parameter bit MD_STALL_EN = 1'b1
) (
  input  logic [5:0] D_op,
  input  logic [5:0] D_funct,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       md_busy,
  output logic       stall
);

  tuse_t use_d;
  logic  rs_e_hz;
  logic  rs_m_hz;
  logic  rt_e_hz;
  logic  rt_m_hz;
  logic  md_hz;

  assign use_d = decode_tuse(D_op, D_funct);

  // A producer only forces a stall when its result arrives later than the
  // consumer needs it; $0 is never a real dependency.
  always_comb begin
    rs_e_hz = use_d.rs_read && (D_rs != 5'd0) && (D_rs == E_wa) && (use_d.rs_tuse < E_tnew);
    rs_m_hz = use_d.rs_read && (D_rs != 5'd0) && (D_rs == M_wa) && (use_d.rs_tuse < M_tnew);
    rt_e_hz = use_d.rt_read && (D_rt != 5'd0) && (D_rt == E_wa) && (use_d.rt_tuse < E_tnew);
    rt_m_hz = use_d.rt_read && (D_rt != 5'd0) && (D_rt == M_wa) && (use_d.rt_tuse < M_tnew);
    md_hz   = MD_STALL_EN && md_busy && use_d.md_op;
  end

  assign stall = rs_e_hz | rs_m_hz | rt_e_hz | rt_m_hz | md_hz;

endmodule

// File: rtl/d_nextpc_ctrl.sv
// d_nextpc_ctrl: decode-stage driver of the fetch PC register.
//   Holds the IF/ID register, forwards rs/rt from E and M, resolves
//   beq/bne/j/jal/jr in D and raises stall on data or mult/div hazards.
//   Inputs : clk, reset (sync, active-high), F_pc, F_instr, grf_rs, grf_rt,
//            E_wa/E_tnew/E_wd, M_wa/M_tnew/M_wd, md_busy
//   Outputs: D_instr, D_PC, D_rs_val, D_rt_val, PCSrc, immediate_26,
//            immediate_32, ra (jr target), stall
//   The delay slot is never flushed: the instruction behind a branch enters
//   D normally.
module d_nextpc_ctrl
  import d_ctrl_pkg::*;
#(
  parameter logic [31:0] D_PC_RESET  = 32'h0000_0000,
  parameter bit          MD_STALL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic [31:0] grf_rs,
  input  logic [31:0] grf_rt,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [31:0] E_wd,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic [31:0] M_wd,
  input  logic        md_busy,
  output logic [31:0] D_instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_rs_val,
  output logic [31:0] D_rt_val,
  output logic [2:0]  PCSrc,
  output logic [25:0] immediate_26,
  output logic [31:0] immediate_32,
  output logic [31:0] ra,
  output logic        stall
);

  logic [5:0] d_op;
  logic [5:0] d_funct;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  pcsrc_e     pc_sel;

  // IF/ID register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      D_instr <= 32'h0000_0000;
      D_PC    <= D_PC_RESET;
    end else if (!stall) begin
      D_instr <= F_instr;
      D_PC    <= F_pc;
    end
  end

  assign d_op    = D_instr[31:26];
  assign d_rs    = D_instr[25:21];
  assign d_rt    = D_instr[20:16];
  assign d_funct = D_instr[5:0];

  // E is younger than M, so its value takes precedence when both match.
  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] grf_val,
                                      input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                      input logic [31:0] e_wd, input logic [4:0] m_wa,
                                      input logic [1:0] m_tnew, input logic [31:0] m_wd);
    if (addr == 5'd0)                         return 32'h0000_0000;
    else if (addr == e_wa && e_tnew == 2'd0)  return e_wd;
    else if (addr == m_wa && m_tnew == 2'd0)  return m_wd;
    else                                      return grf_val;
  endfunction

  always_comb begin
    D_rs_val = fwd(d_rs, grf_rs, E_wa, E_tnew, E_wd, M_wa, M_tnew, M_wd);
    D_rt_val = fwd(d_rt, grf_rt, E_wa, E_tnew, E_wd, M_wa, M_tnew, M_wd);
  end

  d_hazard_unit #(
    .MD_STALL_EN (MD_STALL_EN)
  ) u_hazard (
    .D_op    (d_op),
    .D_funct (d_funct),
    .D_rs    (d_rs),
    .D_rt    (d_rt),
    .E_wa    (E_wa),
    .E_tnew  (E_tnew),
    .M_wa    (M_wa),
    .M_tnew  (M_tnew),
    .md_busy (md_busy),
    .stall   (stall)
  );

  // During a stall the operands may still be stale, so no redirect is
  // issued; the PC is held anyway.
  always_comb begin
    pc_sel = PCSRC_SEQ;
    if (!stall) begin
      case (d_op)
        OP_BEQ:        if (D_rs_val == D_rt_val) pc_sel = PCSRC_BRANCH;
        OP_BNE:        if (D_rs_val != D_rt_val) pc_sel = PCSRC_BRANCH;
        OP_J, OP_JAL:  pc_sel = PCSRC_JUMP;
        OP_RTYPE:      if (d_funct == FN_JR) pc_sel = PCSRC_JR;
        default:       pc_sel = PCSRC_SEQ;
      endcase
    end
  end

  assign PCSrc        = pc_sel;
  assign immediate_26 = D_instr[25:0];
  assign immediate_32 = {{16{D_instr[15]}}, D_instr[15:0]};
  assign ra           = D_rs_val;

endmodule

// File: tb/tb_d_nextpc_ctrl.sv
module tb_d_nextpc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic [31:0] grf_rs;
  logic [31:0] grf_rt;
  logic [4:0]  E_wa;
  logic [1:0]  E_tnew;
  logic [31:0] E_wd;
  logic [4:0]  M_wa;
  logic [1:0]  M_tnew;
  logic [31:0] M_wd;
  logic        md_busy;
  logic [31:0] D_instr;
  logic [31:0] D_PC;
  logic [31:0] D_rs_val;
  logic [31:0] D_rt_val;
  logic [2:0]  PCSrc;
  logic [25:0] immediate_26;
  logic [31:0] immediate_32;
  logic [31:0] ra;
  logic        stall;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_BEQ00   = 32'h1000_FFFE; // beq $0,$0,-2
  localparam logic [31:0] I_BEQ12   = 32'h1022_0003; // beq $1,$2,3
  localparam logic [31:0] I_BNE34   = 32'h1464_0001; // bne $3,$4,1
  localparam logic [31:0] I_JR31    = 32'h03E0_0008; // jr $31
  localparam logic [31:0] I_SW56    = 32'hACC5_0000; // sw $5,0($6)
  localparam logic [31:0] I_MFLO    = 32'h0000_4012; // mflo $8
  localparam logic [31:0] I_ADDU300 = 32'h0000_1821; // addu $3,$0,$0
  localparam logic [31:0] I_MULT12  = 32'h0022_0018; // mult $1,$2

  d_nextpc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .F_pc         (F_pc),
    .F_instr      (F_instr),
    .grf_rs       (grf_rs),
    .grf_rt       (grf_rt),
    .E_wa         (E_wa),
    .E_tnew       (E_tnew),
    .E_wd         (E_wd),
    .M_wa         (M_wa),
    .M_tnew       (M_tnew),
    .M_wd         (M_wd),
    .md_busy      (md_busy),
    .D_instr      (D_instr),
    .D_PC         (D_PC),
    .D_rs_val     (D_rs_val),
    .D_rt_val     (D_rt_val),
    .PCSrc        (PCSrc),
    .immediate_26 (immediate_26),
    .immediate_32 (immediate_32),
    .ra           (ra),
    .stall        (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Clear all hazard sources, present an instruction at F and clock it into D.
  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0; md_busy = 1'b0;
    F_instr = instr;
    F_pc    = pc;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; F_pc = 32'h0000_3000; F_instr = I_BEQ00;
    grf_rs = 32'h0; grf_rt = 32'h0;
    E_wa = 5'd0; E_tnew = 2'd0; E_wd = 32'h0;
    M_wa = 5'd0; M_tnew = 2'd0; M_wd = 32'h0;
    md_busy = 1'b0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", D_instr, 32'h0);
    check("rst_pc", D_PC, 32'h0);
    check("rst_pcsrc", {29'h0, PCSrc}, 32'd0);
    check("rst_stall", {31'h0, stall}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rel_instr", D_instr, I_BEQ00);
    check("rel_pc", D_PC, 32'h0000_3000);
    check("rel_pcsrc", {29'h0, PCSrc}, 32'd1);
    check("imm32_neg", immediate_32, 32'hFFFF_FFFE);
    check("imm26", {6'h0, immediate_26}, 32'h0000_FFFE);

    // beq $1,$2 waiting on E producer of $1
    load(I_BEQ12, 32'h0000_3004);
    grf_rs = 32'd10; grf_rt = 32'd20;
    E_wa = 5'd1; E_tnew = 2'd1; E_wd = 32'd99;
    #1;
    check("beq_stall", {31'h0, stall}, 32'd1);
    check("beq_stall_pcsrc", {29'h0, PCSrc}, 32'd0);
    F_instr = I_ADDU300; F_pc = 32'h0000_3008;
    @(posedge clk); #1;
    check("beq_hold_instr", D_instr, I_BEQ12);
    check("beq_hold_pc", D_PC, 32'h0000_3004);
    E_tnew = 2'd0; E_wd = 32'd20;
    #1;
    check("beq_go_stall", {31'h0, stall}, 32'd0);
    check("beq_go_rs", D_rs_val, 32'd20);
    check("beq_taken", {29'h0, PCSrc}, 32'd1);
    check("imm32_pos", immediate_32, 32'd3);
    E_wd = 32'd21;
    #1;
    check("beq_not_taken", {29'h0, PCSrc}, 32'd0);

    // bne $3,$4 with rs forwarded from M
    load(I_BNE34, 32'h0000_3010);
    M_wa = 5'd3; M_tnew = 2'd0; M_wd = 32'd5; grf_rs = 32'd7; grf_rt = 32'd5;
    #1;
    check("bne_rs_fwd", D_rs_val, 32'd5);
    check("bne_rt_grf", D_rt_val, 32'd5);
    check("bne_not_taken", {29'h0, PCSrc}, 32'd0);
    M_wd = 32'd6;
    #1;
    check("bne_taken", {29'h0, PCSrc}, 32'd1);

    // jr $31: E beats M
    load(I_JR31, 32'h0000_3020);
    grf_rs = 32'h0000_1234;
    E_wa = 5'd31; E_tnew = 2'd0; E_wd = 32'h0000_3040;
    M_wa = 5'd31; M_tnew = 2'd0; M_wd = 32'h0000_3000;
    #1;
    check("jr_ra_e", ra, 32'h0000_3040);
    check("jr_pcsrc", {29'h0, PCSrc}, 32'd3);
    E_wa = 5'd0;
    #1;
    check("jr_ra_m", ra, 32'h0000_3000);
    E_wa = 5'd31; E_tnew = 2'd1;
    #1;
    check("jr_stall", {31'h0, stall}, 32'd1);
    check("jr_stall_pcsrc", {29'h0, PCSrc}, 32'd0);

    // sw $5,0($6): rt Tuse 2, rs Tuse 1
    load(I_SW56, 32'h0000_3030);
    E_wa = 5'd5; E_tnew = 2'd3;
    #1;
    check("sw_rt_tnew3", {31'h0, stall}, 32'd1);
    E_tnew = 2'd2;
    #1;
    check("sw_rt_tnew2", {31'h0, stall}, 32'd0);
    E_tnew = 2'd1;
    #1;
    check("sw_rt_tnew1", {31'h0, stall}, 32'd0);
    E_wa = 5'd6; E_tnew = 2'd2;
    #1;
    check("sw_rs_e", {31'h0, stall}, 32'd1);
    E_wa = 5'd0; M_wa = 5'd6; M_tnew = 2'd2;
    #1;
    check("sw_rs_m", {31'h0, stall}, 32'd1);
    M_tnew = 2'd1;
    #1;
    check("sw_rs_m_ok", {31'h0, stall}, 32'd0);

    // mflo under md_busy for five cycles
    load(I_MFLO, 32'h0000_3040);
    F_instr = I_ADDU300; F_pc = 32'h0000_3044;
    md_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("mflo_busy_stall", {31'h0, stall}, 32'd1);
      check("mflo_busy_hold", D_instr, I_MFLO);
      @(posedge clk); #1;
    end
    md_busy = 1'b0;
    #1;
    check("mflo_free", {31'h0, stall}, 32'd0);
    @(posedge clk); #1;
    check("mflo_next_instr", D_instr, I_ADDU300);
    check("mflo_next_pc", D_PC, 32'h0000_3044);

    // addu $3,$0,$0: md_busy and $0 producers never stall
    md_busy = 1'b1; E_wa = 5'd0; E_tnew = 2'd3; M_wa = 5'd0; M_tnew = 2'd3;
    #1;
    check("addu_no_stall", {31'h0, stall}, 32'd0);
    check("addu_pcsrc", {29'h0, PCSrc}, 32'd0);

    // mult: md interlock and Tuse 1 operands
    load(I_MULT12, 32'h0000_3050);
    md_busy = 1'b1;
    #1;
    check("mult_md_stall", {31'h0, stall}, 32'd1);
    md_busy = 1'b0; E_wa = 5'd2; E_tnew = 2'd2;
    #1;
    check("mult_rt_stall", {31'h0, stall}, 32'd1);
    E_tnew = 2'd1;
    #1;
    check("mult_rt_ok", {31'h0, stall}, 32'd0);

    // reset in the middle of a stall
    load(I_BEQ12, 32'h0000_3060);
    E_wa = 5'd1; E_tnew = 2'd2;
    #1;
    check("pre_rst_stall", {31'h0, stall}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_instr", D_instr, 32'h0);
    check("mid_rst_pc", D_PC, 32'h0);
    check("mid_rst_stall", {31'h0, stall}, 32'd0);
    check("mid_rst_pcsrc", {29'h0, PCSrc}, 32'd0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
